// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit core: fetch FSM states, the
// instruction queue entry layout and the HLT opcode.
package cpu_pkg;

    localparam int         ADDR_W  = 16;
    localparam int         INSTR_W = 16;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {pc, instr} entries with push, pop and flush.
// Storage is not reset; only pointers and occupancy are.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    // Explicit wrap so non-power-of-two depths (3) index correctly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push_i && !pop_i)      count_q <= count_q + CW'(1);
            else if (pop_i && !push_i) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, imem req/ack handshake, redirect/halt handling.
// Optional FETCH_HLT_PREDECODE_EN stops requesting once a HLT word has been fetched.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter int                QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  pc_plus2,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               hlt,
    output logic               halted
);
    localparam int                CW         = $clog2(QDEPTH + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] BOOT_PC    = RESET_PC & ALIGN_MASK;

    fetch_state_e      state_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] fpc_q;
    logic              stale_q;

    fetch_entry_t      head;
    fetch_entry_t      push_data;
    logic [CW-1:0]     count;
    logic              pop;
    logic              push;
    logic              flush;
    logic              halt_take;
    logic              can_issue;
    logic              fetch_block;
    logic [ADDR_W-1:0] redirect_tgt;

    assign instr_valid  = (count != '0);
    assign pop          = instr_valid & instr_ready;
    assign redirect_tgt = redirect_pc & ALIGN_MASK;
    assign halt_take    = (state_q != HALT) & hlt & pop & ~redirect;
    assign flush        = ((state_q != HALT) & redirect) | halt_take;
    // A redirect or halt in the ack cycle throws that word away.
    assign push         = (state_q == WAIT) & imem_ack & ~stale_q & ~redirect & ~halt_take;
    assign can_issue    = (count < CW'(QDEPTH)) & ~fetch_block;
    assign push_data    = '{pc: addr_q, instr: imem_rdata};

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (head),
        .count_o     (count)
    );

`ifdef FETCH_HLT_PREDECODE_EN
    logic hlt_seen_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hlt_seen_q <= 1'b0;
        end else if (redirect) begin
            hlt_seen_q <= 1'b0;
        end else if (push && (imem_rdata[15:12] == OP_HLT)) begin
            hlt_seen_q <= 1'b1;
        end
    end

    assign fetch_block = hlt_seen_q;
`else
    assign fetch_block = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            req_q   <= 1'b0;
            addr_q  <= '0;
            fpc_q   <= BOOT_PC;
            stale_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (redirect) begin
                        fpc_q   <= redirect_tgt;
                        addr_q  <= redirect_tgt;
                        req_q   <= 1'b1;
                        state_q <= WAIT;
                    end else if (halt_take) begin
                        state_q <= HALT;
                    end else if (can_issue) begin
                        addr_q  <= fpc_q;
                        req_q   <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        fpc_q <= redirect_tgt;
                        if (imem_ack) begin
                            // Handshake just closed, so the new target can go out now.
                            stale_q <= 1'b0;
                            addr_q  <= redirect_tgt;
                        end else begin
                            stale_q <= 1'b1;
                        end
                    end else if (halt_take) begin
                        stale_q <= 1'b0;
                        state_q <= HALT;
                        if (imem_ack) req_q <= 1'b0;
                    end else if (imem_ack) begin
                        if (!stale_q) fpc_q <= fpc_q + PC_STEP;
                        stale_q <= 1'b0;
                        req_q   <= 1'b0;
                        state_q <= RUN;
                    end
                end
                HALT: begin
                    // Let an in-flight request complete, then stay idle.
                    if (req_q && imem_ack) req_q <= 1'b0;
                end
                default: begin
                    state_q <= HALT;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign halted    = (state_q == HALT);
    assign instr     = instr_valid ? head.instr : '0;
    assign instr_pc  = instr_valid ? head.pc : '0;
    assign pc_plus2  = instr_valid ? (head.pc + PC_STEP) : '0;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the 16-bit single-issue core. Owns the PC and fetches one 16-bit instruction per request from instruction memory over a req/ack handshake. Buffers fetched words in a small queue and presents them, with their PC and PC+2, to the decode-stage control unit. Consumes the decode-side redirect (taken branch or BR target) and halt indications to flush, retarget or stop fetching.

## Interface
- `RESET_PC`, default 16'h0000: PC of the first fetch after reset.
- `QDEPTH`, default 2: instruction queue entries; legal range 2..4.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `imem_req` out 1: fetch request; held high with stable `imem_addr` until acked.
- `imem_addr` out 16: byte address of the word requested; always even.
- `imem_ack` in 1: response valid; may assert in the same cycle as `imem_req`.
- `imem_rdata` in 16: instruction word, valid with `imem_ack`.
- `instr` out 16: head-of-queue instruction to decode.
- `instr_pc` out 16: PC of `instr`.
- `pc_plus2` out 16: `instr_pc` + 2, mod 2^16.
- `instr_valid` out 1: queue head valid.
- `instr_ready` in 1: decode accepts the head this cycle; low means stall.
- `redirect` in 1: taken branch; single-cycle pulse.
- `redirect_pc` in 16: new fetch PC; bit 0 is ignored and forced to 0.
- `hlt` in 1: decode is accepting a HLT instruction this cycle.
- `halted` out 1: fetch permanently stopped.

## Operation
- **State machine:**
  - `RUN` (no request outstanding) and `WAIT` (`imem_req` high, awaiting ack) are the fetching states.
  - `HALT` is terminal; only `rst` exits it.
- **Issuing a request:** in `RUN`, when `count < QDEPTH`, assert `imem_req` with `imem_addr = fpc` and go to `WAIT`.
- **Acked request:**
  - On ack, if the `stale` flag is clear, push {fpc, `imem_rdata`} and set fpc += 2.
  - If the same cycle has a pop, push and pop both occur and count is unchanged.
  - Then return to `RUN`.
- **Queue full:** no new request is made until a pop occurs. At most one request is outstanding at any time.
- **Queue head:** pop when `instr_valid & instr_ready`. `instr_valid = (count != 0)`.
- **Redirect:**
  - Flush the queue (count = 0) and set fpc = `redirect_pc`.
  - If in `WAIT` and not acked this cycle, set `stale`. `imem_req` stays high, the ack is discarded, and `stale` clears on that ack.
  - A redirect coincident with an ack discards that ack's data.
- **Halt:** when `hlt` is high and a pop occurs, flush the queue, drop `imem_req` once any outstanding ack arrives, and enter `HALT`. `halted` = 1.
- **Redirect and hlt in the same cycle:** redirect wins and `hlt` is ignored.
- **Wrap-around:** fpc 16'hFFFE + 2 wraps to 16'h0000, with no error.

## Timing
- **Reset:**
  - Outputs: `imem_req` = 0, `instr_valid` = 0, `halted` = 0, `instr`/`instr_pc`/`pc_plus2` = 0.
  - Internal: fpc = `RESET_PC`, count = 0, `stale` = 0, state = `RUN`.
- **First request:** `imem_req` rises in the first clock after `rst` deasserts.
- **Ack to decode:** an ack at cycle N gives `instr_valid` at N+1. There is no bypass.
- **Back-to-back fetch:** with same-cycle ack, one instruction per 2 cycles (`RUN` → `WAIT` → `RUN`).
- **Redirect:** a redirect at cycle N gives `instr_valid` = 0 at N+1. A new request to `redirect_pc` is issued at N+1 if no request is outstanding.
- **`rst` mid-request:** the request is abandoned immediately; there is no stale tracking across reset.
- **Handshake rule:** `imem_addr` must not change while `imem_req` is high and unacked.

## Configuration
- `FETCH_HLT_PREDECODE_EN`:
  - **Defined:** an acked, non-stale word with `imem_rdata[15:12]` == 4'hF blocks further requests until a redirect or until halt completes. This saves wasted fetches past HLT.
  - **Undefined:** fetch continues past HLT until the `hlt` input arrives.
  - Architectural behaviour at decode is identical either way.

## Structure
- **Shared package `cpu_pkg`:**
  - Opcode constant `OP_HLT` = 4'hF.
  - Fetch state enum {`RUN`, `WAIT`, `HALT`}.
  - Address width constant 16.
  - Queue entry typedef {pc[15:0], instr[15:0]}.
- **One sub-module `fetch_queue`:** parameterised circular FIFO with push/pop/flush, count, and head output.
- The FSM, PC and stale logic live in `fetch_unit`.

## Test plan
- **Reset fetch:** `RESET_PC` = 16'h0000, memory acks same cycle, `instr_ready` = 1 → `imem_addr` sequence 0, 2, 4; `instr_pc`/`pc_plus2` = 0/2, 2/4, 4/6.
- **Stall fill:** `instr_ready` = 0 for 10 cycles → exactly `QDEPTH` (2) requests, then `imem_req` stays 0; on release, words pop in order with no loss.
- **Redirect with stale request:** ack latency 3; redirect to 16'h0040 one cycle after req to 16'h0008 → word from 0x0008 never appears; next `instr_pc` = 16'h0040.
- **Halt:** decode pulses `hlt` on a pop of 16'hF000 at PC 0x000A → `halted` = 1 next cycle; `instr_valid` = 0; no further `imem_req` after any outstanding ack.
- **Wrap and coincidence:** redirect to 16'hFFFE → next `instr_pc` values 16'hFFFE, 16'h0000. Redirect and `hlt` in the same cycle → `halted` stays 0 and fetch resumes at `redirect_pc`.
- **Predecode, macro defined:** fetched 16'hF000 at 0x0004 → no request to 0x0006 while `hlt` is pending.
